// File: rtl/controls.sv
// Shared control encodings: memory command, LSU FSM states and funct3 size codes.
package controls;

    typedef enum logic [2:0] {
        MEM_NONE  = 3'b000,
        MEM_READ  = 3'b001,
        MEM_WRITE = 3'b010
    } mem_op;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        MERGE = 2'b10
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
    import controls::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane, extend it, and build the read-modify-write word.
    always_comb begin
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h0, lane_b};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = '0;
        endcase
        merge_data = word;
        if (funct3 == F3_B) begin
            merge_data[{off, 3'b000} +: 8] = store_data[7:0];
        end else if (funct3 == F3_H) begin
            merge_data[{off[1], 4'b0000} +: 16] = store_data;
        end
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder: runs loads and stores against a word-wide synchronous RAM,
// stalling the core for loads and sub-word read-modify-write stores.
module lsu_mem_responder
    import controls::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  mem_op             mem_rdwr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              stall,
    output logic              access_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_rdata
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [15:0]       wd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              capture;
    logic              is_read, is_write, f3_legal, misaligned, cmd_err;
    logic [31:0]       load_data, merge_data;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign is_read  = (mem_rdwr == MEM_READ);
    assign is_write = (mem_rdwr == MEM_WRITE);

    // Decode funct3 legality and natural alignment of the incoming command.
    always_comb begin
        if (is_read) begin
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        end else begin
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                     ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        cmd_err    = !f3_legal || misaligned;
    end

    lsu_align u_align (
        .word       (ram_rdata),
        .off        (off_q),
        .funct3     (f3_q),
        .store_data (wd_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state and output decode; everything is forced low while reset is held.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        stall      = 1'b0;
        access_err = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = '0;
        rdata      = '0;
        unique case (state_q)
            IDLE: begin
                ram_addr = addr[ADDR_W+1:2];
                if (is_read || is_write) begin
                    if (cmd_err) begin
                        access_err = 1'b1;
                    end else begin
                        ram_en  = 1'b1;
                        capture = 1'b1;
                        if (is_read) begin
                            stall   = 1'b1;
                            state_d = LOAD;
                        end else if (funct3 == F3_W) begin
                            ram_we    = 1'b1;
                            ram_wdata = wdata;
                        end else begin
                            // Sub-word store: fetch the word now, merge next cycle.
                            stall   = 1'b1;
                            state_d = MERGE;
                        end
                    end
                end
            end
            LOAD: begin
                rdata   = load_data;
                state_d = IDLE;
            end
            MERGE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = merge_data;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            capture    = 1'b0;
            stall      = 1'b0;
            access_err = 1'b0;
            ram_en     = 1'b0;
            ram_we     = 1'b0;
            ram_addr   = '0;
            ram_wdata  = '0;
            rdata      = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the command on acceptance; these copies drive LOAD/MERGE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q  <= '0;
            f3_q   <= '0;
            wd_q   <= '0;
            addr_q <= '0;
        end else if (capture) begin
            off_q  <= addr[1:0];
            f3_q   <= funct3;
            wd_q   <= wdata[15:0];
            addr_q <= addr[ADDR_W+1:2];
        end
    end

endmodule
